// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: receiver FSM states,
// keyboard prefix bytes, FIFO entry layout and the frame acceptance rule.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;

    // Entry layout: [9] extended, [8] break, [7:0] scan code
    localparam int unsigned PS2_CODE_W  = 8;
    localparam int unsigned PS2_ENTRY_W = PS2_CODE_W + 2;

    // A frame is good when data plus parity has odd parity and stop is high
    function automatic logic ps2_frame_ok(input logic [7:0] code,
                                          input logic       par,
                                          input logic       stop);
        return (^{code, par}) & stop;
    endfunction

endpackage

// File: rtl/scancode_fifo.sv
// First-word fall-through FIFO for decoded scan-code entries. A push while
// full is dropped and latches the sticky overflow flag unless a pop happens
// in the same cycle, in which case both proceed.
module scancode_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full;
    logic             do_push, do_pop;

    // Push/pop qualification and next pointer/occupancy values
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        ovf_d    = ovf_q | (push & full & ~do_pop);
    end

    // Pointer, occupancy and overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises the device clock/data, deframes
// 11-bit frames on falling PS/2 clock edges, checks parity/stop, runs a
// frame watchdog and queues decoded scan codes in a FIFO.
// Build option: define PS2_PREFIX_DECODE_EN to fold E0/F0 prefix bytes
// into the extended/break flags of the following entry; without it every
// accepted byte is queued raw.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DAT,
    input  logic                          rd_en,
    output logic [PS2_ENTRY_W-1:0]        rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          busy
);

    localparam int unsigned    WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s, ps2_dat_s, fall;

    ps2_state_e             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   err_q, err_d;
`ifdef PS2_PREFIX_DECODE_EN
    logic                   ext_q, ext_d, brk_q, brk_d;
`endif

    logic                   push;
    logic [PS2_ENTRY_W-1:0] push_data;
    logic                   fifo_empty;

    // Input synchronisers, idle-high so reset cannot fake a falling edge
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q[0] <= PS2_CLK;
            dat_sync_q[0] <= PS2_DAT;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_q[i] <= clk_sync_q[i-1];
                dat_sync_q[i] <= dat_sync_q[i-1];
            end
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q & ~ps2_clk_s;

    // Receiver state, watchdog and prefix flag registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            wd_q      <= '0;
            err_q     <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
`ifdef PS2_PREFIX_DECODE_EN
            ext_q     <= ext_d;
            brk_q     <= brk_d;
`endif
        end
    end

    // Deframing, frame check, watchdog and prefix decode
    // The watchdog is loaded with 1 on each edge so that its value equals
    // the number of cycles since the edge; this makes the abort land exactly
    // TIMEOUT_CYCLES after the detected edge.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        wd_d      = (state_q == IDLE) ? '0 : wd_q + WD_W'(1);
        err_d     = 1'b0;
        push      = 1'b0;
        push_data = '0;
`ifdef PS2_PREFIX_DECODE_EN
        ext_d     = ext_q;
        brk_d     = brk_q;
`endif
        if (fall) begin
            case (state_q)
                IDLE: begin
                    wd_d = '0;
                    if (!ps2_dat_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        wd_d      = WD_W'(1);
                    end
                end
                DATA: begin
                    shift_d = {ps2_dat_s, shift_q[7:1]};
                    wd_d    = WD_W'(1);
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    par_d   = ps2_dat_s;
                    wd_d    = WD_W'(1);
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    wd_d    = '0;
                    if (ps2_frame_ok(shift_q, par_q, ps2_dat_s)) begin
`ifdef PS2_PREFIX_DECODE_EN
                        if (shift_q == PS2_PREFIX_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_PREFIX_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_data = {ext_q, brk_q, shift_q};
                            ext_d     = 1'b0;
                            brk_d     = 1'b0;
                        end
`else
                        push      = 1'b1;
                        push_data = {2'b00, shift_q};
`endif
                    end else begin
                        err_d = 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
                        ext_d = 1'b0;
                        brk_d = 1'b0;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && wd_q == WD_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            wd_d      = '0;
            err_d     = 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
            ext_d     = 1'b0;
            brk_d     = 1'b0;
`endif
        end
    end

    scancode_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_ENTRY_W)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst       (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (rd_en),
        .head_data (rd_data),
        .empty     (fifo_empty),
        .count     (count),
        .overflow  (overflow)
    );

    assign rd_valid  = ~fifo_empty;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: drives PS/2 frames and compares the DUT with a
// queue-based reference model of the decoded key stream.
module tb_ps2_scancode_rx;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned TMO   = 300;
    localparam int unsigned HALF  = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b1;
    logic          PS2_CLK  = 1'b1;
    logic          PS2_DAT  = 1'b1;
    logic          rd_en    = 1'b0;
    logic [9:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overflow;
    logic          busy;

    ps2_scancode_rx #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .frame_err (frame_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc++;

    int err_seen = 0;
    always @(negedge CLOCK_50) if (frame_err === 1'b1) err_seen++;

    int n_pass  = 0;
    int n_total = 0;
    int last_fall = 0;

    // Reference model: expected FIFO contents, prefix state, overflow, errors
    logic [9:0] exp_q[$];
    bit         m_ext, m_brk, m_ovf;
    int         exp_err = 0;

    function automatic void m_push(input logic [9:0] e);
        if (exp_q.size() == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(e);
    endfunction

    function automatic void m_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ext = 1'b0; m_brk = 1'b0; exp_err++;
            return;
        end
`ifdef PS2_PREFIX_DECODE_EN
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            m_push({m_ext, m_brk, b});
            m_ext = 1'b0; m_brk = 1'b0;
        end
`else
        m_push({2'b00, b});
`endif
    endfunction

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par_flip, input bit stop);
        return {stop, (~^b) ^ par_flip, b, 1'b0};
    endfunction

    task automatic ps2_fall(input bit v);
        @(negedge CLOCK_50);
        PS2_DAT = v;
        repeat (HALF) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        last_fall = cyc;
    endtask

    task automatic ps2_rise();
        repeat (HALF) @(negedge CLOCK_50);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_fall(bits[i]);
            ps2_rise();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop);
        send_bits(frame_bits(b, par_flip, stop), 11);
        repeat (2 * SYNC + 2) @(negedge CLOCK_50);
        m_frame(b, !par_flip && stop);
    endtask

    task automatic pop_one();
        @(negedge CLOCK_50);
        rd_en = 1'b1;
        @(negedge CLOCK_50);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1; rd_en = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        exp_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge CLOCK_50);
        n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); else n_pass++;
        n_total++; if (count !== '0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
        n_total++; if (rd_data !== 10'h000) $display("FAIL reset_rd_data: got %h expected 000", rd_data); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_single();
        send_bits(frame_bits(8'h1C, 1'b0, 1'b1), 10);
        ps2_fall(1'b1);
        repeat (SYNC) @(negedge CLOCK_50);
        n_total++; if (rd_valid !== 1'b0) $display("FAIL single_early_valid: got %b expected 0", rd_valid); else n_pass++;
        @(negedge CLOCK_50);
        n_total++; if (rd_valid !== 1'b1) $display("FAIL single_valid_latency: got %b expected 1", rd_valid); else n_pass++;
        n_total++; if (rd_data !== 10'h01C) $display("FAIL single_data: got %h expected 01C", rd_data); else n_pass++;
        n_total++; if (count !== CW'(1)) $display("FAIL single_count: got %0d expected 1", count); else n_pass++;
        ps2_rise();
        m_frame(8'h1C, 1'b1);
        pop_one();
        void'(exp_q.pop_front());
        n_total++; if (count !== '0) $display("FAIL single_pop_count: got %0d expected 0", count); else n_pass++;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL single_pop_valid: got %b expected 0", rd_valid); else n_pass++;
    endtask

    task automatic test_prefix();
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
`ifdef PS2_PREFIX_DECODE_EN
        n_total++; if (rd_data !== 10'h375) $display("FAIL prefix_head: got %h expected 375", rd_data); else n_pass++;
`else
        n_total++; if (rd_data !== 10'h0E0) $display("FAIL prefix_head: got %h expected 0E0", rd_data); else n_pass++;
`endif
        n_total++; if (count !== CW'(exp_q.size())) $display("FAIL prefix_count: got %0d expected %0d", count, exp_q.size()); else n_pass++;
        for (int i = 0; i < DEPTH + 1; i++) begin
            n_total++; if (rd_valid !== (exp_q.size() != 0)) $display("FAIL prefix_drain_valid: got %b expected %b", rd_valid, exp_q.size() != 0); else n_pass++;
            if (exp_q.size() == 0) break;
            n_total++; if (rd_data !== exp_q[0]) $display("FAIL prefix_drain_data: got %h expected %h", rd_data, exp_q[0]); else n_pass++;
            pop_one();
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_parity_err();
        send_frame(8'h1C, 1'b1, 1'b1);
        n_total++; if (err_seen !== exp_err) $display("FAIL parity_err_pulses: got %0d expected %0d", err_seen, exp_err); else n_pass++;
        n_total++; if (count !== '0) $display("FAIL parity_err_count: got %0d expected 0", count); else n_pass++;
        send_frame(8'h1C, 1'b0, 1'b1);
        n_total++; if (rd_data !== 10'h01C) $display("FAIL parity_recover_data: got %h expected 01C", rd_data); else n_pass++;
        n_total++; if (count !== CW'(1)) $display("FAIL parity_recover_count: got %0d expected 1", count); else n_pass++;
        n_total++; if (err_seen !== exp_err) $display("FAIL parity_recover_pulses: got %0d expected %0d", err_seen, exp_err); else n_pass++;
        pop_one();
        void'(exp_q.pop_front());
    endtask

    task automatic test_overflow();
        do_reset();
        for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b0, 1'b1);
        n_total++; if (count !== CW'(DEPTH)) $display("FAIL ovf_count: got %0d expected %0d", count, DEPTH); else n_pass++;
        n_total++; if (overflow !== m_ovf) $display("FAIL ovf_flag: got %b expected %b", overflow, m_ovf); else n_pass++;
        // Stop-bit edge of 0x0A coincides with a pop while full
        send_bits(frame_bits(8'h0A, 1'b0, 1'b1), 10);
        ps2_fall(1'b1);
        repeat (SYNC) @(negedge CLOCK_50);
        rd_en = 1'b1;
        @(negedge CLOCK_50);
        rd_en = 1'b0;
        ps2_rise();
        repeat (2) @(negedge CLOCK_50);
        void'(exp_q.pop_front());
        m_frame(8'h0A, 1'b1);
        n_total++; if (count !== CW'(exp_q.size())) $display("FAIL ovf_pushpop_count: got %0d expected %0d", count, exp_q.size()); else n_pass++;
        for (int i = 0; i < DEPTH + 1; i++) begin
            n_total++; if (rd_valid !== (exp_q.size() != 0)) $display("FAIL ovf_drain_valid: got %b expected %b", rd_valid, exp_q.size() != 0); else n_pass++;
            if (exp_q.size() == 0) break;
            n_total++; if (rd_data !== exp_q[0]) $display("FAIL ovf_drain_data: got %h expected %h", rd_data, exp_q[0]); else n_pass++;
            pop_one();
            void'(exp_q.pop_front());
        end
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else n_pass++;
        do_reset();
        @(negedge CLOCK_50);
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_reset_clear: got %b expected 0", overflow); else n_pass++;
    endtask

    task automatic test_timeout();
        int t0;
        int first_err;
        logic busy_at_err;
        logic busy_before;
        first_err   = -1;
        busy_at_err = 1'bx;
        busy_before = 1'b0;
        send_bits(frame_bits(8'hA5, 1'b0, 1'b1), 5);
        t0 = last_fall;
        while (cyc < t0 + int'(SYNC + TMO) + 10) begin
            @(negedge CLOCK_50);
            if (cyc == t0 + int'(SYNC + TMO) - 1) busy_before = busy;
            if (frame_err === 1'b1 && first_err < 0) begin
                first_err   = cyc;
                busy_at_err = busy;
            end
        end
        m_frame(8'h00, 1'b0);
        n_total++; if (first_err != t0 + int'(SYNC + TMO)) $display("FAIL timeout_latency: got cycle %0d expected %0d", first_err, t0 + int'(SYNC + TMO)); else n_pass++;
        n_total++; if (busy_before !== 1'b1) $display("FAIL timeout_busy_before: got %b expected 1", busy_before); else n_pass++;
        n_total++; if (busy_at_err !== 1'b0) $display("FAIL timeout_busy_after: got %b expected 0", busy_at_err); else n_pass++;
        n_total++; if (err_seen !== exp_err) $display("FAIL timeout_pulses: got %0d expected %0d", err_seen, exp_err); else n_pass++;
        send_frame(8'h29, 1'b0, 1'b1);
        n_total++; if (rd_data !== 10'h029) $display("FAIL timeout_next_data: got %h expected 029", rd_data); else n_pass++;
        n_total++; if (count !== CW'(1)) $display("FAIL timeout_next_count: got %0d expected 1", count); else n_pass++;
        pop_one();
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_midframe();
        int e0;
        send_bits(frame_bits(8'h3C, 1'b0, 1'b1), 5);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        exp_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
        e0 = err_seen;
        send_frame(8'h5A, 1'b0, 1'b1);
        n_total++; if (err_seen !== e0) $display("FAIL midreset_err: got %0d pulses expected %0d", err_seen, e0); else n_pass++;
        n_total++; if (count !== CW'(1)) $display("FAIL midreset_count: got %0d expected 1", count); else n_pass++;
        n_total++; if (rd_data !== 10'h05A) $display("FAIL midreset_data: got %h expected 05A", rd_data); else n_pass++;
        pop_one();
        void'(exp_q.pop_front());
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        do_reset();
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            send_frame(b, r == 0, r != 1);
            if ($urandom_range(0, 1) == 1) begin
                n_total++; if (rd_valid !== (exp_q.size() != 0)) $display("FAIL rand_valid: got %b expected %b", rd_valid, exp_q.size() != 0); else n_pass++;
                if (exp_q.size() != 0) begin
                    n_total++; if (rd_data !== exp_q[0]) $display("FAIL rand_data: got %h expected %h", rd_data, exp_q[0]); else n_pass++;
                end
                pop_one();
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        n_total++; if (count !== CW'(exp_q.size())) $display("FAIL rand_count: got %0d expected %0d", count, exp_q.size()); else n_pass++;
        n_total++; if (overflow !== m_ovf) $display("FAIL rand_overflow: got %b expected %b", overflow, m_ovf); else n_pass++;
        n_total++; if (err_seen !== exp_err) $display("FAIL rand_err_pulses: got %0d expected %0d", err_seen, exp_err); else n_pass++;
        for (int i = 0; i < DEPTH + 1; i++) begin
            n_total++; if (rd_valid !== (exp_q.size() != 0)) $display("FAIL rand_drain_valid: got %b expected %b", rd_valid, exp_q.size() != 0); else n_pass++;
            if (exp_q.size() == 0) break;
            n_total++; if (rd_data !== exp_q[0]) $display("FAIL rand_drain_data: got %h expected %h", rd_data, exp_q[0]); else n_pass++;
            pop_one();
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_parity_err();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
